// File: rtl/sdram_arbiter_pkg.sv
// Shared SDRAM arbiter types: FSM state encoding, client index and default bus widths
// shared with the SDRAM controller.
package sdram_arbiter_pkg;

  localparam int unsigned AWIDTH_DEF = 22;
  localparam int unsigned DWIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } arb_state_t;

  typedef logic client_idx_t;

  localparam client_idx_t CLIENT0 = 1'b0;
  localparam client_idx_t CLIENT1 = 1'b1;

endpackage

// File: rtl/sdram_arbiter_rr_pick2.sv
// Two-way winner select: round-robin against last_grant, or fixed priority to
// client 0 when FIXED_PRIO is set.
module rr_pick2
  import sdram_arbiter_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        req0,
  input  logic        req1,
  input  client_idx_t last_grant,
  output logic        any_req,
  output client_idx_t winner
);

  // NOTE: every output gets a default before any branch, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    any_req = req0 | req1;
    winner  = CLIENT0;
    if (req0 && req1) begin
      if (!FIXED_PRIO) begin
        winner = (last_grant == CLIENT0) ? CLIENT1 : CLIENT0;
      end
    end else if (req1) begin
      winner = CLIENT1;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Shares one SDRAM controller request port between two clients, one transaction
// outstanding at a time, with read data steered back to the owning client.
module sdram_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int unsigned AWIDTH     = AWIDTH_DEF,
  parameter int unsigned DWIDTH     = DWIDTH_DEF,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c0_req,
  input  logic              c0_wr,
  input  logic [AWIDTH-1:0] c0_addr,
  input  logic [DWIDTH-1:0] c0_wdata,
  output logic              c0_ack,
  output logic [DWIDTH-1:0] c0_rdata,
  output logic              c0_rdone,
  input  logic              c1_req,
  input  logic              c1_wr,
  input  logic [AWIDTH-1:0] c1_addr,
  input  logic [DWIDTH-1:0] c1_wdata,
  output logic              c1_ack,
  output logic [DWIDTH-1:0] c1_rdata,
  output logic              c1_rdone,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DWIDTH-1:0] mem_rdata,
  input  logic              mem_rdone
);

  arb_state_t        state_q, state_d;
  client_idx_t       last_grant_q, last_grant_d;
  client_idx_t       owner_q, owner_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_wr_q, mem_wr_d;
  logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DWIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DWIDTH-1:0] c0_rdata_q, c0_rdata_d;
  logic [DWIDTH-1:0] c1_rdata_q, c1_rdata_d;
  logic              c0_rdone_q, c0_rdone_d;
  logic              c1_rdone_q, c1_rdone_d;

  logic        any_req;
  client_idx_t winner;

  rr_pick2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_pick (
    .req0       (c0_req),
    .req1       (c1_req),
    .last_grant (last_grant_q),
    .any_req    (any_req),
    .winner     (winner)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    mem_req_d    = mem_req_q;
    mem_wr_d     = mem_wr_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    c0_rdata_d   = c0_rdata_q;
    c1_rdata_d   = c1_rdata_q;
    c0_rdone_d   = 1'b0;
    c1_rdone_d   = 1'b0;
    c0_ack       = 1'b0;
    c1_ack       = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          mem_req_d    = 1'b1;
          owner_d      = winner;
          last_grant_d = winner;
          state_d      = ISSUE;
          if (winner == CLIENT1) begin
            mem_wr_d    = c1_wr;
            mem_addr_d  = c1_addr;
            mem_wdata_d = c1_wdata;
          end else begin
            mem_wr_d    = c0_wr;
            mem_addr_d  = c0_addr;
            mem_wdata_d = c0_wdata;
          end
        end
      end

      // The ack goes straight through so the owner sees it in the accepting cycle;
      // a write is complete at that point, a read still owes its data.
      ISSUE: begin
        c0_ack = mem_ack && (owner_q == CLIENT0);
        c1_ack = mem_ack && (owner_q == CLIENT1);
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = mem_wr_q ? IDLE : WAIT_RD;
        end
      end

      WAIT_RD: begin
        if (mem_rdone) begin
          state_d = IDLE;
          if (owner_q == CLIENT1) begin
            c1_rdata_d = mem_rdata;
            c1_rdone_d = 1'b1;
          end else begin
            c0_rdata_d = mem_rdata;
            c0_rdone_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its _d input regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= CLIENT1;
      owner_q      <= CLIENT0;
      mem_req_q    <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      c0_rdata_q   <= '0;
      c1_rdata_q   <= '0;
      c0_rdone_q   <= 1'b0;
      c1_rdone_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      mem_req_q    <= mem_req_d;
      mem_wr_q     <= mem_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      c0_rdata_q   <= c0_rdata_d;
      c1_rdata_q   <= c1_rdata_d;
      c0_rdone_q   <= c0_rdone_d;
      c1_rdone_q   <= c1_rdone_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign c0_rdata  = c0_rdata_q;
  assign c1_rdata  = c1_rdata_q;
  assign c0_rdone  = c0_rdone_q;
  assign c1_rdone  = c1_rdone_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: a round-robin and a fixed-priority instance share client and
// controller stimulus; one is observed at a time against a transaction-level model.
module tb_sdram_arbiter;
  import sdram_arbiter_pkg::*;

  localparam int AW = 22;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset;
  always #4 clk = ~clk;

  logic          c0_req, c1_req, c0_wr, c1_wr;
  logic [AW-1:0] c0_addr, c1_addr;
  logic [DW-1:0] c0_wdata, c1_wdata;
  logic          mem_ack, mem_rdone;
  logic [DW-1:0] mem_rdata;

  logic          o_c0_ack   [2];
  logic          o_c1_ack   [2];
  logic [DW-1:0] o_c0_rdata [2];
  logic [DW-1:0] o_c1_rdata [2];
  logic          o_c0_rdone [2];
  logic          o_c1_rdone [2];
  logic          o_mem_req  [2];
  logic          o_mem_wr   [2];
  logic [AW-1:0] o_mem_addr [2];
  logic [DW-1:0] o_mem_wdata[2];

  sdram_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .FIXED_PRIO(1'b0)) u_rr (
    .clk(clk), .reset(reset),
    .c0_req(c0_req), .c0_wr(c0_wr), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c0_ack(o_c0_ack[0]), .c0_rdata(o_c0_rdata[0]), .c0_rdone(o_c0_rdone[0]),
    .c1_req(c1_req), .c1_wr(c1_wr), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
    .c1_ack(o_c1_ack[0]), .c1_rdata(o_c1_rdata[0]), .c1_rdone(o_c1_rdone[0]),
    .mem_req(o_mem_req[0]), .mem_wr(o_mem_wr[0]), .mem_addr(o_mem_addr[0]),
    .mem_wdata(o_mem_wdata[0]), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_rdone(mem_rdone)
  );

  sdram_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .FIXED_PRIO(1'b1)) u_fp (
    .clk(clk), .reset(reset),
    .c0_req(c0_req), .c0_wr(c0_wr), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c0_ack(o_c0_ack[1]), .c0_rdata(o_c0_rdata[1]), .c0_rdone(o_c0_rdone[1]),
    .c1_req(c1_req), .c1_wr(c1_wr), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
    .c1_ack(o_c1_ack[1]), .c1_rdata(o_c1_rdata[1]), .c1_rdone(o_c1_rdone[1]),
    .mem_req(o_mem_req[1]), .mem_wr(o_mem_wr[1]), .mem_addr(o_mem_addr[1]),
    .mem_wdata(o_mem_wdata[1]), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_rdone(mem_rdone)
  );

  int            vectors;
  int            fails;
  int            ui;
  bit            fixed_mode;
  int            last_g;
  logic [DW-1:0] exp_rdata [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [31:0] r;
    r = $urandom;
    return r[AW-1:0];
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [31:0] r;
    r = $urandom;
    return r[DW-1:0];
  endfunction

  function automatic logic [31:0] obs_ack(input int c);
    return (c == 0) ? 32'(o_c0_ack[ui]) : 32'(o_c1_ack[ui]);
  endfunction

  function automatic logic [31:0] obs_rdone(input int c);
    return (c == 0) ? 32'(o_c0_rdone[ui]) : 32'(o_c1_rdone[ui]);
  endfunction

  function automatic logic [31:0] obs_rdata(input int c);
    return (c == 0) ? 32'(o_c0_rdata[ui]) : 32'(o_c1_rdata[ui]);
  endfunction

  // Arbitration rule: a lone requester wins; on a tie fixed mode favours client 0,
  // otherwise the client that was not granted last time wins.
  function automatic int model_winner(input bit r0, input bit r1);
    if (r0 && r1) return fixed_mode ? 0 : 1 - last_g;
    return r0 ? 0 : 1;
  endfunction

  task automatic model_reset();
    last_g       = 1;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_mem_req"},   32'(o_mem_req[ui]), 0);
    check({tag, "_mem_wr"},    32'(o_mem_wr[ui]), 0);
    check({tag, "_mem_addr"},  32'(o_mem_addr[ui]), 0);
    check({tag, "_mem_wdata"}, 32'(o_mem_wdata[ui]), 0);
    check({tag, "_rdone"},     obs_rdone(0) | obs_rdone(1), 0);
    check({tag, "_rdata"},     obs_rdata(0) | obs_rdata(1), 0);
    check({tag, "_ack"},       obs_ack(0) | obs_ack(1), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    c0_req = 1'b0; c1_req = 1'b0; c0_wr = 1'b0; c1_wr = 1'b0;
    c0_addr = '0; c1_addr = '0; c0_wdata = '0; c1_wdata = '0;
    mem_ack = 1'b0; mem_rdone = 1'b0; mem_rdata = '0;
    #1;
    check_reset_vals("rst");
    tick();
    tick();
    reset = 1'b0;
    model_reset();
    tick();
    check_reset_vals("post_rst");
  endtask

  task automatic raise(input int c);
    if (c == 0) begin
      c0_wr = 1'($urandom_range(1, 0)); c0_addr = rand_addr(); c0_wdata = rand_data(); c0_req = 1'b1;
    end else begin
      c1_wr = 1'($urandom_range(1, 0)); c1_addr = rand_addr(); c1_wdata = rand_data(); c1_req = 1'b1;
    end
  endtask

  // One complete transaction from the controller's side: wait for the grant, check the
  // issued fields, ack after ack_dly cycles, and for reads return rdata rd_dly cycles
  // after the ack. The winner drops its request after ack unless told to keep it.
  task automatic serve(input int ack_dly, input int rd_dly, input logic [DW-1:0] rdata,
                       input bit keep0, input bit keep1, output int who, output int lat);
    bit            r0, r1;
    int            w, o;
    logic          wr_e;
    logic [AW-1:0] addr_e;
    logic [DW-1:0] wd_e;
    r0  = c0_req;
    r1  = c1_req;
    lat = 0;
    who = -1;
    while (!o_mem_req[ui] && lat < 20) begin
      tick();
      lat++;
    end
    if (!o_mem_req[ui]) begin
      check("grant_timeout", 32'(o_mem_req[ui]), 1);
      return;
    end
    w      = model_winner(r0, r1);
    o      = 1 - w;
    who    = w;
    last_g = w;
    wr_e   = (w == 0) ? c0_wr : c1_wr;
    addr_e = (w == 0) ? c0_addr : c1_addr;
    wd_e   = (w == 0) ? c0_wdata : c1_wdata;
    for (int k = 0; k <= ack_dly; k++) begin
      if (k > 0) tick();
      check("mem_req_held", 32'(o_mem_req[ui]), 1);
      check("mem_wr",       32'(o_mem_wr[ui]), 32'(wr_e));
      check("mem_addr",     32'(o_mem_addr[ui]), 32'(addr_e));
      check("mem_wdata",    32'(o_mem_wdata[ui]), 32'(wd_e));
      check("ack_early",    obs_ack(0) | obs_ack(1), 0);
    end
    mem_ack = 1'b1;
    #1;
    check("ack_owner", obs_ack(w), 1);
    check("ack_other", obs_ack(o), 0);
    tick();
    mem_ack = 1'b0;
    #1;
    check("mem_req_drop", 32'(o_mem_req[ui]), 0);
    check("ack_pulse", obs_ack(0) | obs_ack(1), 0);
    check("rdone_at_ack", obs_rdone(0) | obs_rdone(1), 0);
    if (w == 0) begin
      if (keep0) c0_addr = rand_addr(); else c0_req = 1'b0;
    end else begin
      if (keep1) c1_addr = rand_addr(); else c1_req = 1'b0;
    end
    if (!wr_e) begin
      for (int k = 1; k < rd_dly; k++) begin
        tick();
        check("rdone_early", obs_rdone(0) | obs_rdone(1), 0);
      end
      mem_rdone = 1'b1;
      mem_rdata = rdata;
      tick();
      mem_rdone = 1'b0;
      mem_rdata = rand_data();
      check("rdone_owner", obs_rdone(w), 1);
      check("rdata_owner", obs_rdata(w), 32'(rdata));
      check("rdone_other", obs_rdone(o), 0);
      check("rdata_other", obs_rdata(o), 32'(exp_rdata[o]));
      exp_rdata[w] = rdata;
    end
    tick();
    check("rdone_pulse", obs_rdone(0) | obs_rdone(1), 0);
    check("rdata0_hold", obs_rdata(0), 32'(exp_rdata[0]));
    check("rdata1_hold", obs_rdata(1), 32'(exp_rdata[1]));
  endtask

  task automatic random_phase(input int n);
    int who, lat;
    for (int it = 0; it < n; it++) begin
      if (!o_mem_req[ui]) begin
        if (!c0_req && $urandom_range(1, 0) == 1) raise(0);
        if (!c1_req && $urandom_range(1, 0) == 1) raise(1);
        if (!c0_req && !c1_req) raise(int'($urandom_range(1, 0)));
      end
      serve(int'($urandom_range(3, 0)), int'($urandom_range(4, 1)), rand_data(), 1'b0, 1'b0, who, lat);
    end
    for (int d = 0; d < 3 && (c0_req || c1_req || o_mem_req[ui]); d++) begin
      serve(1, 1, rand_data(), 1'b0, 1'b0, who, lat);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time bound");
    $fatal(1, "watchdog");
  end

  initial begin
    int who, lat;
    vectors    = 0;
    fails      = 0;
    ui         = 0;
    fixed_mode = 1'b0;
    model_reset();
    do_reset();

    // c0 read of 0x000100, data 0xBEEF three cycles after the ack
    c0_wr = 1'b0; c0_addr = 22'h000100; c0_wdata = rand_data(); c0_req = 1'b1;
    serve(2, 3, 16'hBEEF, 1'b0, 1'b0, who, lat);
    check("t1_owner", 32'(who), 0);
    check("t1_latency", 32'(lat), 1);
    check("t1_rdata", obs_rdata(0), 32'h0000BEEF);

    // c1 write to the top address, ack held off five cycles
    c1_wr = 1'b1; c1_addr = 22'h3FFFFF; c1_wdata = 16'hA55A; c1_req = 1'b1;
    serve(5, 1, '0, 1'b0, 1'b0, who, lat);
    check("t2_owner", 32'(who), 1);
    check("t2_latency", 32'(lat), 1);
    check("t2_rdata1", obs_rdata(1), 0);

    // stray controller pulses while idle
    mem_rdone = 1'b1; mem_rdata = rand_data(); mem_ack = 1'b1;
    #1;
    check("idle_ack", obs_ack(0) | obs_ack(1), 0);
    tick();
    mem_rdone = 1'b0; mem_ack = 1'b0;
    check("idle_rdone", obs_rdone(0) | obs_rdone(1), 0);
    check("idle_rdata0", obs_rdata(0), 32'h0000BEEF);
    check("idle_rdata1", obs_rdata(1), 0);
    check("idle_mem_req", 32'(o_mem_req[ui]), 0);

    random_phase(30);

    // both clients request continuously: grants alternate starting with client 0
    do_reset();
    c0_wr = 1'b0; c0_addr = rand_addr(); c1_wr = 1'b0; c1_addr = rand_addr();
    c0_req = 1'b1; c1_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      serve(1, 2, rand_data(), 1'b1, (i == 7) ? 1'b0 : 1'b1, who, lat);
      check("rr_order", 32'(who), 32'(i % 2));
    end
    serve(1, 2, rand_data(), 1'b0, 1'b0, who, lat);
    check("rr_tail", 32'(who), 0);

    // reset asserted while a read is outstanding
    c0_wr = 1'b0; c0_addr = rand_addr(); c0_req = 1'b1;
    lat = 0;
    while (!o_mem_req[ui] && lat < 20) begin
      tick();
      lat++;
    end
    check("rst_t_grant", 32'(o_mem_req[ui]), 1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    c0_req  = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check_reset_vals("rst_mid");
    tick();
    reset = 1'b0;
    model_reset();
    mem_rdone = 1'b1;
    mem_rdata = rand_data();
    tick();
    mem_rdone = 1'b0;
    check("stray_rdone", obs_rdone(0) | obs_rdone(1), 0);
    check("stray_rdata", obs_rdata(0) | obs_rdata(1), 0);
    c1_wr = 1'b0; c1_addr = rand_addr(); c1_req = 1'b1;
    serve(1, 2, rand_data(), 1'b0, 1'b0, who, lat);
    check("rst_t_c1_owner", 32'(who), 1);
    check("rst_t_c1_latency", 32'(lat), 1);

    // fixed-priority instance: client 0 wins every tie until it stops asking
    ui         = 1;
    fixed_mode = 1'b1;
    do_reset();
    c0_wr = 1'b0; c0_addr = rand_addr(); c1_wr = 1'b0; c1_addr = rand_addr();
    c0_req = 1'b1; c1_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      serve(1, 2, rand_data(), (i == 7) ? 1'b0 : 1'b1, 1'b1, who, lat);
      check("fp_order", 32'(who), 0);
    end
    serve(1, 2, rand_data(), 1'b0, 1'b0, who, lat);
    check("fp_c1_after_drop", 32'(who), 1);

    random_phase(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares one SDRAM controller request port between two clients: client 0 (display refill reader) and client 1 (test/CPU read-write port).
- Sits between the clients and the SDRAM controller, all on the 125 MHz memory clock.
- At most one transaction is outstanding. Grants are round-robin by default, or fixed-priority to client 0.
- Read data is steered back to whichever client owns the outstanding read.

Parameters:
- AWIDTH, 22, word address width.
- DWIDTH, 16, data width.
- FIXED_PRIO, 0: 0 = round-robin; 1 = client 0 always wins a tie.

Ports:
- clk  in  1  memory clock.
- reset  in  1  asynchronous, active-high reset.
- c0_req, c1_req  in  1  request. Client holds it, with wr/addr/wdata, stable until ack.
- c0_wr, c1_wr  in  1  1 = write, 0 = read.
- c0_addr, c1_addr  in  AWIDTH  word address.
- c0_wdata, c1_wdata  in  DWIDTH  write data.
- c0_ack, c1_ack  out  1  one-cycle pulse: request accepted by the controller.
- c0_rdata, c1_rdata  out  DWIDTH  read data, valid when rdone is high.
- c0_rdone, c1_rdone  out  1  one-cycle pulse: read data valid.
- mem_req  out  1  request to controller.
- mem_wr  out  1  write flag to controller.
- mem_addr  out  AWIDTH  address to controller.
- mem_wdata  out  DWIDTH  write data to controller.
- mem_ack  in  1  controller accepted mem_req this cycle.
- mem_rdata  in  DWIDTH  controller read data.
- mem_rdone  in  1  controller read data valid (one-cycle pulse).

Behaviour:
- Reset values:
  - state=IDLE, last_grant=1 (so client 0 wins first), owner=0.
  - mem_req=0, mem_wr=0, mem_addr=0, mem_wdata=0.
  - c*_rdata=0, c*_rdone=0. c*_ack is combinational, so it is 0 while in IDLE.
- State IDLE:
  - If any c*_req is high, choose the winner:
    - FIXED_PRIO=1: client 0 wins if requesting.
    - FIXED_PRIO=0: when both request, the client != last_grant wins.
  - Register the winner's wr/addr/wdata onto mem_*, set mem_req=1, owner=winner, last_grant=winner, then go to ISSUE.
  - Latency from c*_req rising to mem_req high is 1 cycle.
- State ISSUE:
  - mem_* are held stable until mem_ack.
  - c{owner}_ack = mem_ack, combinational, only while in ISSUE.
  - On mem_ack: mem_req goes 0. If mem_wr=1, go to IDLE (a write is complete at ack); otherwise go to WAIT_RD.
- State WAIT_RD:
  - Wait for mem_rdone; there is no timeout.
  - On mem_rdone: c{owner}_rdata <= mem_rdata, c{owner}_rdone <= 1 for one cycle (registered, so 1 cycle after mem_rdone), then go to IDLE.
  - The other client's rdata holds its previous value.
- A mem_rdone arriving in IDLE or ISSUE is ignored. mem_ack arriving outside ISSUE is ignored.
- At least one IDLE cycle separates transactions. A client that registers ack and drops req the next cycle is never double-issued.
- A client dropping req before ack is a protocol violation. The latched transaction still completes and the ack still pulses.
- Requests arriving while busy wait; there is no queueing beyond the client's own held req.
- Round-robin guarantee: with both clients continuously requesting, grants strictly alternate 0,1,0,1.
- Reset asserted mid-transaction: return immediately to reset values. The controller is reset by the same signal.
- Widths: no arithmetic; all buses pass through at declared widths.

Decomposition:
- Shared sdram package holds:
  - state enum {IDLE, ISSUE, WAIT_RD} as a 2-bit typedef;
  - the client-index typedef;
  - the AWIDTH/DWIDTH defaults shared with the controller.
- One natural sub-module, rr_pick2: combinational two-way winner select from (req0, req1, last_grant, FIXED_PRIO).
- Steering and the FSM stay in sdram_arbiter.

Test Plan:
- Reset, then c0 read addr=0x000100. Required: mem_req high next cycle with mem_addr=0x000100, mem_wr=0; ack on c0 only. Model returns mem_rdata=0xBEEF with rdone 3 cycles later → c0_rdone pulses 1 cycle after mem_rdone, c0_rdata=0xBEEF, c1_rdone stays 0.
- c1 write addr=0x3FFFFF, wdata=0xA55A. Required: mem_wr=1, mem_addr=0x3FFFFF, mem_wdata=0xA55A held until mem_ack (delayed 5 cycles); c1_ack pulses once; next state IDLE with no rdone.
- Both clients request continuously (reads, model acks in 1 cycle, rdone 2 cycles later) for 8 transactions, FIXED_PRIO=0. Required: owner order 0,1,0,1,0,1,0,1, and each rdone goes to the correct client.
- Same stimulus with FIXED_PRIO=1. Required: all 8 grants go to client 0; client 1 is granted only after c0_req drops.
- Assert reset during WAIT_RD. Required: mem_req=0 and all rdone=0 immediately; a stray mem_rdone after reset is ignored; the next c1 request issues normally.
- mem_rdone pulse injected while IDLE. Required: no c*_rdone pulse, and c*_rdata unchanged.
